// File: rtl/intr_pending_ctrl.sv
// rtl/intr_pending_ctrl.sv - sticky, maskable, acknowledgeable per-channel interrupt pending with overrun counters
module intr_pending_ctrl #(
    parameter int NCH   = 4,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCH-1:0]       pulse_in,
    input  logic [NCH-1:0]       mask,
    input  logic [NCH-1:0]       ack,
    input  logic [NCH-1:0]       ovr_clr,
    output logic [NCH-1:0]       pending,
    output logic [NCH-1:0]       irq_out,
    output logic                 irq_any,
    output logic [NCH*CNT_W-1:0] ovr_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [NCH-1:0]       prev;
    logic [NCH-1:0]       evt;
    logic [NCH-1:0]       ovr_evt;
    logic [NCH-1:0]       next_pending;
    logic [NCH*CNT_W-1:0] next_ovr_cnt;

    // A new event beats a simultaneous ack, and only an unacked event on an
    // already-pending channel counts as a lost tick.
    always_comb begin
        evt          = pulse_in & ~prev;
        ovr_evt      = evt & ~ack & pending;
        next_pending = pending;
        next_ovr_cnt = ovr_cnt;
        for (int i = 0; i < NCH; i++) begin
            if (evt[i]) begin
                next_pending[i] = 1'b1;
            end else if (ack[i]) begin
                next_pending[i] = 1'b0;
            end

            if (ovr_clr[i]) begin
                next_ovr_cnt[i*CNT_W +: CNT_W] = ovr_evt[i] ? CNT_ONE : '0;
            end else if (ovr_evt[i] && (ovr_cnt[i*CNT_W +: CNT_W] != CNT_MAX)) begin
                next_ovr_cnt[i*CNT_W +: CNT_W] = ovr_cnt[i*CNT_W +: CNT_W] + CNT_ONE;
            end
        end
    end

    // prev resets to all ones so inputs held high through reset are not events.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev    <= '1;
            pending <= '0;
            irq_out <= '0;
            irq_any <= 1'b0;
            ovr_cnt <= '0;
        end else begin
            prev    <= pulse_in;
            pending <= next_pending;
            irq_out <= next_pending & mask;
            irq_any <= |(next_pending & mask);
            ovr_cnt <= next_ovr_cnt;
        end
    end

endmodule

// File: tb/tb_intr_pending_ctrl.sv
// tb/tb_intr_pending_ctrl.sv - directed self-checking bench for intr_pending_ctrl
module tb_intr_pending_ctrl;

    localparam int NCH   = 4;
    localparam int CNT_W = 8;

    logic                 clk;
    logic                 reset;
    logic [NCH-1:0]       pulse_in;
    logic [NCH-1:0]       mask;
    logic [NCH-1:0]       ack;
    logic [NCH-1:0]       ovr_clr;
    logic [NCH-1:0]       pending;
    logic [NCH-1:0]       irq_out;
    logic                 irq_any;
    logic [NCH*CNT_W-1:0] ovr_cnt;

    int checks = 0;
    int errors = 0;

    intr_pending_ctrl #(.NCH(NCH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .pulse_in (pulse_in),
        .mask     (mask),
        .ack      (ack),
        .ovr_clr  (ovr_clr),
        .pending  (pending),
        .irq_out  (irq_out),
        .irq_any  (irq_any),
        .ovr_cnt  (ovr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // one clock edge; inputs are driven and outputs sampled on the falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] cnt(input int ch);
        return 32'(ovr_cnt[ch*CNT_W +: CNT_W]);
    endfunction

    initial begin
        reset    = 1'b1;
        pulse_in = 4'b1111;
        mask     = 4'hF;
        ack      = '0;
        ovr_clr  = '0;
        tick();
        tick();
        check("rst_pending", 32'(pending), 32'h0);
        check("rst_irq_out", 32'(irq_out), 32'h0);
        check("rst_irq_any", 32'(irq_any), 32'h0);
        check("rst_ovr_cnt", 32'(ovr_cnt), 32'h0);

        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("held_high_no_evt", 32'(pending), 32'h0);
        end

        pulse_in = 4'b0000;
        tick();
        pulse_in = 4'b0001;
        tick();
        check("ch0_pending", 32'(pending), 32'h1);
        check("ch0_irq_out", 32'(irq_out), 32'h1);
        check("ch0_irq_any", 32'(irq_any), 32'h1);
        tick();
        check("ch0_held_one_evt", cnt(0), 32'h0);
        pulse_in = 4'b0000;
        ack      = 4'b0001;
        tick();
        ack = '0;
        check("ch0_ack_pending", 32'(pending), 32'h0);
        check("ch0_ack_irq_any", 32'(irq_any), 32'h0);

        mask     = 4'b0000;
        pulse_in = 4'b0100;
        tick();
        pulse_in = 4'b0000;
        check("ch2_masked_pending", 32'(pending), 32'h4);
        check("ch2_masked_irq_out", 32'(irq_out), 32'h0);
        check("ch2_masked_irq_any", 32'(irq_any), 32'h0);
        mask = 4'b0100;
        tick();
        check("ch2_unmask_irq_out", 32'(irq_out), 32'h4);
        check("ch2_unmask_irq_any", 32'(irq_any), 32'h1);
        ack = 4'b0100;
        tick();
        ack = '0;
        check("ch2_ack_pending", 32'(pending), 32'h0);
        check("ch2_ack_irq_out", 32'(irq_out), 32'h0);
        check("ch2_ack_irq_any", 32'(irq_any), 32'h0);

        mask = 4'hF;
        for (int k = 0; k < 3; k++) begin
            pulse_in = 4'b0010;
            tick();
            pulse_in = 4'b0000;
            tick();
        end
        check("ch1_ovr_pending", 32'(pending), 32'h2);
        check("ch1_ovr_cnt", cnt(1), 32'd2);
        mask = 4'b0000;
        tick();
        check("ch1_mask_drop_irq", 32'(irq_out), 32'h0);
        check("ch1_mask_keeps_pend", 32'(pending), 32'h2);
        mask    = 4'hF;
        ovr_clr = 4'b0010;
        tick();
        ovr_clr = '0;
        check("ch1_ovr_clr_cnt", cnt(1), 32'd0);
        check("ch1_ovr_clr_pending", 32'(pending), 32'h2);
        ack = 4'b0010;
        tick();
        ack = '0;

        pulse_in = 4'b1000;
        tick();
        pulse_in = 4'b0000;
        tick();
        check("ch3_pending", 32'(pending), 32'h8);
        ack      = 4'b1000;
        pulse_in = 4'b1000;
        tick();
        ack      = '0;
        pulse_in = 4'b0000;
        check("ch3_ack_evt_pending", 32'(pending), 32'h8);
        check("ch3_ack_evt_cnt", cnt(3), 32'd0);
        ack = 4'b1000;
        tick();
        ack = '0;
        check("ch3_cleared", 32'(pending), 32'h0);

        for (int k = 0; k < 300; k++) begin
            pulse_in = 4'b0001;
            tick();
            pulse_in = 4'b0000;
            tick();
        end
        check("ch0_sat_cnt", cnt(0), 32'd255);
        check("ch0_sat_pending", 32'(pending), 32'h1);
        ovr_clr  = 4'b0001;
        pulse_in = 4'b0001;
        tick();
        ovr_clr  = '0;
        pulse_in = 4'b0000;
        check("ch0_clr_with_evt", cnt(0), 32'd1);
        tick();

        for (int k = 0; k < 2; k++) begin
            pulse_in = 4'b1111;
            tick();
            pulse_in = 4'b0000;
            tick();
        end
        check("pre_rst_pending", 32'(pending), 32'hF);
        check("pre_rst_cnt0", cnt(0), 32'd3);
        check("pre_rst_cnt2", cnt(2), 32'd1);
        reset    = 1'b1;
        pulse_in = 4'b1111;
        tick();
        check("mid_rst_pending", 32'(pending), 32'h0);
        check("mid_rst_irq_out", 32'(irq_out), 32'h0);
        check("mid_rst_irq_any", 32'(irq_any), 32'h0);
        check("mid_rst_ovr_cnt", 32'(ovr_cnt), 32'h0);
        reset = 1'b0;
        tick();
        check("rst_evt_discarded", 32'(pending), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
